mmio_port_hub: RTL and testbench

//  Parametrised memory-mapped I/O hub between the CPU data bus and PORT_COUNT peripheral ports.

---
 rtl/mmio_port_hub.sv | 142 ++++++++++++++
 tb/tb_mmio_port_hub.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_hub.sv
// Memory-mapped I/O hub: bus words map onto PORT_COUNT ports of WORDS_PER_PORT words each, plus
// one STATUS word. Writes are staged and committed per port; device input is captured with sticky pending.
module mmio_port_hub #(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned PORT_COUNT     = 4,
   parameter int unsigned WORDS_PER_PORT = 2
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          bus_read,
   input  logic                                          bus_write,
   input  logic [ADDR_W-1:0]                             bus_addr,
   input  logic [DATA_W-1:0]                             bus_d_in,
   output logic [DATA_W-1:0]                             bus_d_out,
   output logic                                          bus_rd_valid,
   output logic                                          bus_err,
   input  logic [PORT_COUNT*WORDS_PER_PORT*DATA_W-1:0]   port_d_in,
   input  logic [PORT_COUNT-1:0]                         port_d_in_valid,
   output logic [PORT_COUNT*WORDS_PER_PORT*DATA_W-1:0]   port_d_out,
   output logic [PORT_COUNT-1:0]                         port_inform_write,
   output logic [PORT_COUNT-1:0]                         port_inform_read
);

   localparam int unsigned NUM_WORDS = PORT_COUNT * WORDS_PER_PORT;

   typedef logic [NUM_WORDS-1:0][DATA_W-1:0] words_t;

   words_t                din_words;
   words_t                staging_q, staging_d;
   words_t                capture_q, capture_d;
   words_t                out_q, out_d;
   logic [PORT_COUNT-1:0] pending_q, pending_d;
   logic [PORT_COUNT-1:0] inform_write_q, inform_write_d;
   logic [PORT_COUNT-1:0] inform_read_q, inform_read_d;
   logic [PORT_COUNT-1:0] clear;
   logic [DATA_W-1:0]     d_out_q, d_out_d;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid_q;
   logic                  err_q, err_d;
   logic                  rd_en;
   logic [NUM_WORDS-1:0]  addr_hit;
   logic                  status_hit;
   logic                  addr_ok;

   assign din_words = port_d_in;

   // Address decode; a simultaneous write takes priority and drops the read.
   always_comb begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         addr_hit[i] = (bus_addr == ADDR_W'(i));
      end
      status_hit = (bus_addr == ADDR_W'(NUM_WORDS));
      addr_ok    = (|addr_hit) | status_hit;
      rd_en      = bus_read & ~bus_write;
      err_d      = (bus_read & bus_write) | ((bus_read | bus_write) & ~addr_ok);
   end

   // Staging and atomic commit on the port's last word
   always_comb begin
      staging_d      = staging_q;
      out_d          = out_q;
      inform_write_d = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (bus_write && addr_hit[i]) begin
            staging_d[i] = bus_d_in;
         end
      end
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
         if (bus_write && addr_hit[p*WORDS_PER_PORT + WORDS_PER_PORT - 1]) begin
            inform_write_d[p] = 1'b1;
            for (int unsigned w = 0; w < WORDS_PER_PORT; w++) begin
               out_d[p*WORDS_PER_PORT + w] = staging_d[p*WORDS_PER_PORT + w];
            end
         end
      end
   end

   // Read data, capture and pending; a capture overrides any clear in the same cycle
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (addr_hit[i]) begin
            rd_data = capture_q[i];
         end
      end
      if (status_hit) begin
         rd_data[PORT_COUNT-1:0] = pending_q;
      end

      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
         inform_read_d[p] = rd_en & addr_hit[p*WORDS_PER_PORT];
      end
      clear = inform_read_d;
      if (bus_write && status_hit) begin
         clear = clear | bus_d_in[PORT_COUNT-1:0];
      end

      capture_d = capture_q;
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
         if (port_d_in_valid[p]) begin
            for (int unsigned w = 0; w < WORDS_PER_PORT; w++) begin
               capture_d[p*WORDS_PER_PORT + w] = din_words[p*WORDS_PER_PORT + w];
            end
         end
      end
      pending_d = (pending_q & ~clear) | port_d_in_valid;
      d_out_d   = rd_en ? rd_data : d_out_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staging_q      <= '0;
         capture_q      <= '0;
         out_q          <= '0;
         pending_q      <= '0;
         inform_write_q <= '0;
         inform_read_q  <= '0;
         d_out_q        <= '0;
         rd_valid_q     <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         staging_q      <= staging_d;
         capture_q      <= capture_d;
         out_q          <= out_d;
         pending_q      <= pending_d;
         inform_write_q <= inform_write_d;
         inform_read_q  <= inform_read_d;
         d_out_q        <= d_out_d;
         rd_valid_q     <= rd_en;
         err_q          <= err_d;
      end
   end

   assign bus_d_out         = d_out_q;
   assign bus_rd_valid      = rd_valid_q;
   assign bus_err           = err_q;
   assign port_d_out        = out_q;
   assign port_inform_write = inform_write_q;
   assign port_inform_read  = inform_read_q;

endmodule

// File: tb/tb_mmio_port_hub.sv
// Bench for mmio_port_hub: directed vector table, random traffic against a word-array model,
// asynchronous reset during a read, and a second 8-port / 1-word / 8-bit instance.
module tb_mmio_port_hub;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int PC = 4;
   localparam int WP = 2;
   localparam int NW = PC * WP;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             bus_read, bus_write;
   logic [AW-1:0]    bus_addr;
   logic [DW-1:0]    bus_d_in, bus_d_out;
   logic             bus_rd_valid, bus_err;
   logic [NW*DW-1:0] port_d_in, port_d_out;
   logic [PC-1:0]    port_d_in_valid, port_inform_write, port_inform_read;

   logic        r8, w8, v8, e8;
   logic [15:0] a8;
   logic [7:0]  di8, do8, cv8, iw8, ir8;
   logic [63:0] pdi8, pdo8;

   mmio_port_hub #(.DATA_W(DW), .ADDR_W(AW), .PORT_COUNT(PC), .WORDS_PER_PORT(WP)) dut (
      .clk(clk), .rst(rst), .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_d_in(bus_d_in), .bus_d_out(bus_d_out), .bus_rd_valid(bus_rd_valid), .bus_err(bus_err),
      .port_d_in(port_d_in), .port_d_in_valid(port_d_in_valid), .port_d_out(port_d_out),
      .port_inform_write(port_inform_write), .port_inform_read(port_inform_read)
   );

   mmio_port_hub #(.DATA_W(8), .ADDR_W(16), .PORT_COUNT(8), .WORDS_PER_PORT(1)) dut8 (
      .clk(clk), .rst(rst), .bus_read(r8), .bus_write(w8), .bus_addr(a8),
      .bus_d_in(di8), .bus_d_out(do8), .bus_rd_valid(v8), .bus_err(e8),
      .port_d_in(pdi8), .port_d_in_valid(cv8), .port_d_out(pdo8),
      .port_inform_write(iw8), .port_inform_read(ir8)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain word arrays indexed by bus address
   logic [15:0] m_stage[NW];
   logic [15:0] m_out[NW];
   logic [15:0] m_cap[NW];
   logic [3:0]  m_pend;
   logic [15:0] e_dout;
   logic        e_valid, e_err;
   logic [3:0]  e_iw, e_ir;

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         m_stage[i] = '0; m_out[i] = '0; m_cap[i] = '0;
      end
      m_pend = '0; e_dout = '0; e_valid = 0; e_err = 0; e_iw = '0; e_ir = '0;
   endtask

   task automatic model_step();
      int a;
      int p;
      logic [3:0] clr;
      a = int'(bus_addr);
      clr = '0; e_valid = 0; e_err = 0; e_iw = '0; e_ir = '0;
      if (bus_read && bus_write) e_err = 1;
      if (bus_write) begin
         if (a < NW) begin
            m_stage[a] = bus_d_in;
            if (a % WP == WP - 1) begin
               p = a / WP;
               for (int w = 0; w < WP; w++) m_out[p*WP + w] = m_stage[p*WP + w];
               e_iw[p] = 1'b1;
            end
         end else if (a == NW) begin
            clr = bus_d_in[3:0];
         end else begin
            e_err = 1;
         end
      end else if (bus_read) begin
         e_valid = 1;
         if (a < NW) begin
            e_dout = m_cap[a];
            if (a % WP == 0) begin
               e_ir[a/WP] = 1'b1;
               clr[a/WP] = 1'b1;
            end
         end else if (a == NW) begin
            e_dout = {12'h000, m_pend};
         end else begin
            e_dout = '0;
            e_err = 1;
         end
      end
      for (int q = 0; q < PC; q++)
         if (port_d_in_valid[q])
            for (int w = 0; w < WP; w++) m_cap[q*WP + w] = port_d_in[(q*WP + w)*DW +: DW];
      m_pend = (m_pend & ~clr) | port_d_in_valid;
   endtask

   function automatic logic [127:0] model_out();
      logic [127:0] r;
      for (int i = 0; i < NW; i++) r[i*16 +: 16] = m_out[i];
      return r;
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " dout"}, bus_d_out, e_dout);
      chk({tag, " rd_valid"}, bus_rd_valid, e_valid);
      chk({tag, " err"}, bus_err, e_err);
      chk({tag, " inform_write"}, port_inform_write, e_iw);
      chk({tag, " inform_read"}, port_inform_read, e_ir);
      chk({tag, " port_d_out"}, port_d_out, model_out());
   endtask

   typedef struct {
      logic        rd, wr;
      logic [15:0] addr, din;
      logic [3:0]  cv;
      logic [15:0] cw0, cw1;
      logic [15:0] e_dout;
      logic        e_valid, e_err;
      logic [3:0]  e_iw, e_ir;
      logic [31:0] e_p1;
   } vec_t;

   function automatic vec_t v(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d, input logic [3:0] cv, input logic [15:0] c0,
                              input logic [15:0] c1, input logic [15:0] ed, input logic ev,
                              input logic ee, input logic [3:0] eiw, input logic [3:0] eir,
                              input logic [31:0] ep1);
      vec_t t;
      t.rd = rd; t.wr = wr; t.addr = a; t.din = d; t.cv = cv; t.cw0 = c0; t.cw1 = c1;
      t.e_dout = ed; t.e_valid = ev; t.e_err = ee; t.e_iw = eiw; t.e_ir = eir; t.e_p1 = ep1;
      return t;
   endfunction

   localparam logic [31:0] P1 = 32'h5555_AAAA;
   vec_t tbl[21];

   initial begin
      tbl[0]  = v(0, 0, 16'd0, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0000, 4'b0000, 32'h0);
      tbl[1]  = v(0, 1, 16'd2, 16'hAAAA, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0000, 4'b0000, 32'h0);
      tbl[2]  = v(0, 1, 16'd3, 16'h5555, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0010, 4'b0000, P1);
      tbl[3]  = v(0, 0, 16'd0, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0000, 4'b0000, P1);
      tbl[4]  = v(0, 0, 16'd0, 16'h0000, 4'b0100, 16'h1234, 16'hBEEF, 16'h0000, 0, 0, 4'b0000, 4'b0000, P1);
      tbl[5]  = v(1, 0, 16'd8, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0004, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[6]  = v(1, 0, 16'd4, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h1234, 1, 0, 4'b0000, 4'b0100, P1);
      tbl[7]  = v(1, 0, 16'd5, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[8]  = v(1, 0, 16'd8, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[9]  = v(1, 0, 16'd4, 16'h0000, 4'b0100, 16'h5678, 16'h0000, 16'h1234, 1, 0, 4'b0000, 4'b0100, P1);
      tbl[10] = v(1, 0, 16'd8, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0004, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[11] = v(0, 1, 16'd8, 16'h0004, 4'b0100, 16'h9999, 16'h0000, 16'h0004, 0, 0, 4'b0000, 4'b0000, P1);
      tbl[12] = v(1, 0, 16'd8, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0004, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[13] = v(0, 1, 16'd8, 16'h0004, 4'b0000, 16'h0000, 16'h0000, 16'h0004, 0, 0, 4'b0000, 4'b0000, P1);
      tbl[14] = v(1, 0, 16'd8, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 4'b0000, 4'b0000, P1);
      tbl[15] = v(1, 0, 16'd4, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h9999, 1, 0, 4'b0000, 4'b0100, P1);
      tbl[16] = v(0, 1, 16'd9, 16'hFFFF, 4'b0000, 16'h0000, 16'h0000, 16'h9999, 0, 1, 4'b0000, 4'b0000, P1);
      tbl[17] = v(1, 0, 16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 4'b0000, 4'b0000, P1);
      tbl[18] = v(1, 1, 16'd2, 16'h1111, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 4'b0000, 4'b0000, P1);
      tbl[19] = v(0, 0, 16'd0, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0000, 4'b0000, P1);
      tbl[20] = v(0, 1, 16'd3, 16'h2222, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0010, 4'b0000, 32'h2222_1111);

      rst = 1'b1;
      bus_read = 0; bus_write = 0; bus_addr = '0; bus_d_in = '0;
      port_d_in = '0; port_d_in_valid = '0;
      r8 = 0; w8 = 0; a8 = '0; di8 = '0; pdi8 = '0; cv8 = '0;
      model_reset();
      #2;
      chk("reset dout", bus_d_out, 0);
      chk("reset rd_valid", bus_rd_valid, 0);
      chk("reset port_d_out", port_d_out, 0);
      chk("reset informs", {port_inform_write, port_inform_read, bus_err}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         bus_read = tbl[i].rd; bus_write = tbl[i].wr; bus_addr = tbl[i].addr;
         bus_d_in = tbl[i].din; port_d_in_valid = tbl[i].cv;
         for (int p = 0; p < PC; p++) begin
            port_d_in[(p*WP)*DW +: DW]     = tbl[i].cw0;
            port_d_in[(p*WP + 1)*DW +: DW] = tbl[i].cw1;
         end
         step();
         chk($sformatf("vec%0d dout", i), bus_d_out, tbl[i].e_dout);
         chk($sformatf("vec%0d rd_valid", i), bus_rd_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d err", i), bus_err, tbl[i].e_err);
         chk($sformatf("vec%0d inform_write", i), port_inform_write, tbl[i].e_iw);
         chk($sformatf("vec%0d inform_read", i), port_inform_read, tbl[i].e_ir);
         chk($sformatf("vec%0d port1_out", i), port_d_out[63:32], tbl[i].e_p1);
      end

      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         bus_read  = (r < 4) || (r == 8);
         bus_write = (r >= 4 && r < 8) || (r == 8);
         case ($urandom_range(0, 15))
            0: bus_addr = 16'hFFFF;
            1: bus_addr = 16'd9;
            default: bus_addr = 16'($urandom_range(0, 8));
         endcase
         bus_d_in = 16'($urandom);
         port_d_in = {$urandom, $urandom, $urandom, $urandom};
         port_d_in_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         step();
         chk_model($sformatf("rnd%0d", i));
      end

      // Asynchronous reset while a read result is being presented
      bus_read = 1; bus_write = 0; bus_addr = 16'd0; port_d_in_valid = '0;
      step();
      chk_model("preread");
      #2;
      rst = 1'b1;
      #1;
      chk("midreset dout", bus_d_out, 0);
      chk("midreset rd_valid", bus_rd_valid, 0);
      chk("midreset port_d_out", port_d_out, 0);
      chk("midreset informs", {port_inform_write, port_inform_read, bus_err}, 0);
      @(posedge clk);
      #1;
      chk("held reset rd_valid", bus_rd_valid, 0);
      bus_read = 0;
      rst = 1'b0;
      model_reset();

      // 8 ports, 1 word each, 8-bit data: every write commits, STATUS at address 8
      w8 = 1; a8 = 16'd3; di8 = 8'h5A;
      @(posedge clk); #1;
      chk("p8 iw a3", iw8, 8'h08);
      chk("p8 out a3", pdo8, 64'h0000_0000_5A00_0000);
      a8 = 16'd5; di8 = 8'hC3;
      @(posedge clk); #1;
      chk("p8 iw a5", iw8, 8'h20);
      chk("p8 out a5", pdo8, 64'h0000_C300_5A00_0000);
      w8 = 0; cv8 = 8'hFF; pdi8 = 64'h8877_6655_4433_2211;
      @(posedge clk); #1;
      cv8 = 8'h00; r8 = 1; a8 = 16'd8;
      @(posedge clk); #1;
      chk("p8 status", {v8, do8}, {1'b1, 8'hFF});
      a8 = 16'd2;
      @(posedge clk); #1;
      chk("p8 read a2", {v8, do8, ir8}, {1'b1, 8'h33, 8'h04});
      a8 = 16'd8;
      @(posedge clk); #1;
      chk("p8 status after read", do8, 8'hFB);
      r8 = 0; w8 = 1; di8 = 8'h0F;
      @(posedge clk); #1;
      w8 = 0; r8 = 1;
      @(posedge clk); #1;
      chk("p8 status after w1c", do8, 8'hF0);
      a8 = 16'd9;
      @(posedge clk); #1;
      chk("p8 oor read", {e8, v8, do8}, {1'b1, 1'b1, 8'h00});
      r8 = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
